dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, requester address width.
REQ-002 SHALL have parameter DATA_W, default 16, data word width.
REQ-003 SHALL have parameter MEM_DEPTH, default 16, number of words in the data memory.
REQ-004 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous active-high reset.
REQ-006 SHALL have ports pN_req  input  1  access request, for N=0,1.
REQ-007 SHALL have ports pN_op  input  2  operation: 00 read word, 01 read byte, 10 write word, 11 write byte.
REQ-008 SHALL have ports pN_addr  input  ADDR_W  word address.
REQ-009 SHALL have ports pN_wdata  input  DATA_W  write data.
REQ-010 SHALL have ports pN_gnt  output  1  one-cycle pulse, request accepted.
REQ-011 SHALL have ports pN_done  output  1  one-cycle pulse, access complete.
REQ-012 SHALL have ports pN_rdata  output  DATA_W  read result.
REQ-013 SHALL have ports pN_err  output  1  error flag, valid with pN_done.
REQ-014 SHALL have port mem_en  output  1  memory access strobe.
REQ-015 SHALL have port mem_we  output  1  write enable, qualified by mem_en.
REQ-016 SHALL have port mem_addr  output  ADDR_W  memory word address.
REQ-017 SHALL have port mem_wdata  output  DATA_W  memory write data.
REQ-018 SHALL have port mem_rdata  input  DATA_W  synchronous read data, valid one cycle after mem_en with mem_we=0.

Function
REQ-019 SHALL implement FSM states IDLE, ISSUE, MERGE, RESP.
REQ-020 SHALL, in IDLE with any req high at edge T, latch the winner's op/addr/wdata, enter ISSUE, and pulse that port's gnt during cycle T+1.
REQ-021 SHALL arbitrate round-robin: single requester wins; on a tie, the port not served last wins; the last-served bit resets to 1 so p0 wins the first tie.
REQ-022 SHALL, in ISSUE, drive mem_en=1 and mem_addr=latched addr; mem_we=1 and mem_wdata=wdata for write word; mem_we=0 otherwise.
REQ-023 SHALL complete reads and word writes as ISSUE->RESP: done at T+2, 2-cycle latency from accept.
REQ-024 SHALL complete byte write as ISSUE (read) -> MERGE (mem_we=1, mem_wdata={mem_rdata[15:8], wdata[7:0]}) -> RESP: done at T+3.
REQ-025 SHALL, in RESP, pulse the served port's done and update its rdata: word read = mem_rdata; byte read = {8'h00, mem_rdata[7:0]}; writes leave rdata unchanged.
REQ-026 SHALL treat addr >= MEM_DEPTH as an error: ISSUE drives mem_en=0, RESP pulses done with err=1, memory untouched, rdata unchanged.
REQ-027 SHALL return RESP->IDLE unconditionally; next accept is evaluated in IDLE, so peak throughput is one access per 3 cycles (4 for byte write).
REQ-028 SHALL ignore req, op, addr and wdata changes after acceptance; requests arriving outside IDLE wait.
REQ-029 SHALL hold pN_rdata stable between that port's read completions.
REQ-030 SHALL never assert gnt or done on the non-served port, and never assert mem_we outside ISSUE/MERGE.

Reset
REQ-031 SHALL, on rst high at an edge, force IDLE, last-served bit=1, all gnt/done/err=0, pN_rdata=0, mem_en=mem_we=0, mem_addr=mem_wdata=0.
REQ-032 SHALL, on reset during ISSUE or MERGE, abandon the access: no further mem_we, no done for that request.

Structure
REQ-033 SHALL place op encodings, FSM state enum and MEM_DEPTH default in shared package dmem_ctrl_pkg.
REQ-034 SHALL implement tie-breaking in one sub-module rr_arb2 (2-way round-robin, req[1:0] in, one-hot grant out, last-served update on accept).

Verification
REQ-035 SHALL cover: after reset, p0 read word addr 0 with mem[0]=16'h3142 -> p0_gnt at T+1, p0_done at T+2, p0_rdata=16'h3142, err=0.
REQ-036 SHALL cover: p1 write byte 16'h00AB to addr 4 holding 16'h5678 -> mem_we only in MERGE, done at T+3; subsequent word read returns 16'h56AB.
REQ-037 SHALL cover: p0 and p1 requesting same cycle after reset -> p0 served first, p1 served next; repeated ties alternate.
REQ-038 SHALL cover: p0 read addr 16 -> mem_en stays 0, p0_done with p0_err=1, p0_rdata unchanged.
REQ-039 SHALL cover: byte read addr 6 holding 16'hDEAD -> p0_rdata=16'h00AD.
REQ-040 SHALL cover: rst asserted in the MERGE cycle of a byte write -> no mem_we afterwards, no done, FSM in IDLE next cycle.

Source files
------------

// File: rtl/dmem_ctrl_pkg.sv
// Shared definitions for the data-memory arbiter: op encodings, FSM states
// and the default memory depth.
package dmem_ctrl_pkg;

    localparam int unsigned MEM_DEPTH_DEF = 16;

    typedef enum logic [1:0] {
        OP_RD_WORD = 2'b00,
        OP_RD_BYTE = 2'b01,
        OP_WR_WORD = 2'b10,
        OP_WR_BYTE = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_MERGE = 2'b10,
        ST_RESP  = 2'b11
    } state_e;

    function automatic logic is_read(input op_e op);
        return (op == OP_RD_WORD) || (op == OP_RD_BYTE);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: a lone requester wins; on a tie the port that
// was not served last wins.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] grant
);

    // Index of the port served most recently; 1 after reset so p0 wins the first tie.
    logic last;

    always_comb begin
        grant = '0;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last ? 2'b01 : 2'b10;
            default: grant = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last <= 1'b1;
        end else if (accept && (grant != 2'b00)) begin
            last <= grant[1];
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single synchronous data memory, with word and
// byte reads/writes; byte writes are done as read-merge-write.
module dmem_arbiter
    import dmem_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned MEM_DEPTH = MEM_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              p0_req,
    input  logic [1:0]        p0_op,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic              p0_done,
    output logic [DATA_W-1:0] p0_rdata,
    output logic              p0_err,

    input  logic              p1_req,
    input  logic [1:0]        p1_op,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic              p1_done,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              p1_err,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(MEM_DEPTH);

    state_e            state;
    op_e               op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              port_q;
    logic              bad_q;
    logic [1:0]        gnt_q;
    logic [1:0]        done_q;
    logic [1:0]        err_q;
    logic [DATA_W-1:0] rdata_q [2];

    logic [1:0]        req;
    logic [1:0]        grant;
    logic              accept;
    logic              win;
    op_e               sel_op;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_bad;
    logic              resp_load;
    logic [DATA_W-1:0] rd_fmt;

    assign req    = {p1_req, p0_req};
    assign accept = (state == ST_IDLE) && (req != 2'b00);
    assign win    = grant[1];

    rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .accept (accept),
        .grant  (grant)
    );

    always_comb begin
        sel_op    = op_e'(win ? p1_op : p0_op);
        sel_addr  = win ? p1_addr  : p0_addr;
        sel_wdata = win ? p1_wdata : p0_wdata;
        sel_bad   = ({1'b0, sel_addr} >= DEPTH_LIM);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            op_q       <= OP_RD_WORD;
            addr_q     <= '0;
            wdata_q    <= '0;
            port_q     <= 1'b0;
            bad_q      <= 1'b0;
            gnt_q      <= '0;
            done_q     <= '0;
            err_q      <= '0;
            rdata_q[0] <= '0;
            rdata_q[1] <= '0;
        end else begin
            gnt_q  <= '0;
            done_q <= '0;
            err_q  <= '0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        op_q    <= sel_op;
                        addr_q  <= sel_addr;
                        wdata_q <= sel_wdata;
                        port_q  <= win;
                        bad_q   <= sel_bad;
                        gnt_q   <= grant;
                        state   <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if ((op_q == OP_WR_BYTE) && !bad_q) begin
                        state <= ST_MERGE;
                    end else begin
                        state          <= ST_RESP;
                        done_q[port_q] <= 1'b1;
                        err_q[port_q]  <= bad_q;
                    end
                end
                ST_MERGE: begin
                    state          <= ST_RESP;
                    done_q[port_q] <= 1'b1;
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                    if (resp_load) begin
                        rdata_q[port_q] <= rd_fmt;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Memory strobes decode straight from the state so the byte merge can use
    // mem_rdata in the same cycle it arrives; rst gates them so a reset in
    // ISSUE/MERGE cannot complete a write.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state)
            ST_ISSUE: begin
                if (!bad_q) begin
                    mem_en   = 1'b1;
                    mem_addr = addr_q;
                    if (op_q == OP_WR_WORD) begin
                        mem_we    = 1'b1;
                        mem_wdata = wdata_q;
                    end
                end
            end
            ST_MERGE: begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = addr_q;
                mem_wdata = {mem_rdata[DATA_W-1:8], wdata_q[7:0]};
            end
            default: ;
        endcase
        if (rst) begin
            mem_en = 1'b0;
            mem_we = 1'b0;
        end
    end

    always_comb begin
        resp_load = (state == ST_RESP) && is_read(op_q) && !bad_q;
        rd_fmt    = (op_q == OP_RD_BYTE) ? DATA_W'(mem_rdata[7:0]) : mem_rdata;
    end

    // Read data is only valid during RESP, so it is forwarded alongside done
    // and captured for the hold period that follows.
    assign p0_rdata = (resp_load && !port_q) ? rd_fmt : rdata_q[0];
    assign p1_rdata = (resp_load &&  port_q) ? rd_fmt : rdata_q[1];

    assign p0_gnt  = gnt_q[0];
    assign p1_gnt  = gnt_q[1];
    assign p0_done = done_q[0];
    assign p1_done = done_q[1];
    assign p0_err  = err_q[0];
    assign p1_err  = err_q[1];

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: table of accesses, scoreboard of
// expected completions, plus tie, error and reset-in-MERGE sequences.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        preload = 1'b1;

    logic        p0_req = 1'b0, p1_req = 1'b0;
    logic [1:0]  p0_op = '0, p1_op = '0;
    logic [15:0] p0_addr = '0, p1_addr = '0;
    logic [15:0] p0_wdata = '0, p1_wdata = '0;
    logic        p0_gnt, p1_gnt, p0_done, p1_done, p0_err, p1_err;
    logic [15:0] p0_rdata, p1_rdata;
    logic        mem_en, mem_we;
    logic [15:0] mem_addr, mem_wdata;
    logic [15:0] mem_rdata = '0;

    logic [15:0] mem [16];

    int npass  = 0;
    int ntotal = 0;

    typedef struct {
        int          port;
        logic [15:0] rdata;
        logic        err;
    } sb_t;
    sb_t sb[$];

    typedef struct {
        int          port;
        logic [1:0]  op;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] rexp;
    } vec_t;
    vec_t tbl [12];

    logic [15:0] exp_last [2];

    dmem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_DEPTH(16)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_op(p0_op), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_done(p0_done), .p0_rdata(p0_rdata), .p0_err(p0_err),
        .p1_req(p1_req), .p1_op(p1_op), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_done(p1_done), .p1_rdata(p1_rdata), .p1_err(p1_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] init_val(input int i);
        case (i)
            0:       return 16'h3142;
            4:       return 16'h5678;
            6:       return 16'hDEAD;
            default: return 16'h1000 + 16'(i);
        endcase
    endfunction

    // Synchronous memory model: read data appears the cycle after mem_en.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 16; i++) mem[i] <= init_val(i);
        end else if (mem_en) begin
            if (mem_addr < 16) begin
                if (mem_we) mem[mem_addr[3:0]] <= mem_wdata;
                else        mem_rdata <= mem[mem_addr[3:0]];
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntotal++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Scoreboard consumer: every done pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (p0_done || p1_done) begin
            sb_t e;
            int  dport;
            dport = p1_done ? 1 : 0;
            if (p0_done && p1_done) begin
                ntotal++;
                $display("FAIL both_done: got p0_done=1 p1_done=1 expected one");
            end
            if (sb.size() == 0) begin
                ntotal++;
                $display("FAIL unexpected_done: got done on p%0d expected none", dport);
            end else begin
                e = sb.pop_front();
                chk("sb_port", 32'(dport), 32'(e.port));
                chk("sb_rdata", dport ? p1_rdata : p0_rdata, e.rdata);
                chk("sb_err", dport ? p1_err : p0_err, e.err);
            end
        end
    end

    task automatic set_port(input int port, input logic req, input logic [1:0] op,
                            input logic [15:0] addr, input logic [15:0] wdata);
        if (port == 0) begin
            p0_req = req; p0_op = op; p0_addr = addr; p0_wdata = wdata;
        end else begin
            p1_req = req; p1_op = op; p1_addr = addr; p1_wdata = wdata;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        preload = 1'b0;
        exp_last[0] = '0;
        exp_last[1] = '0;
    endtask

    // Single access from an idle DUT; called at a negedge, returns at a negedge
    // with the FSM back in IDLE.
    task automatic do_access(input int port, input logic [1:0] op, input logic [15:0] addr,
                             input logic [15:0] wdata, input logic [15:0] rexp);
        logic       bad;
        int         lat;
        logic [7:0] gm, ogm, dm, em, wm, exp_em, exp_wm;
        sb_t        e;
        bad = (addr >= 16);
        if (!bad && !op[1]) exp_last[port] = rexp;
        e.port = port; e.rdata = exp_last[port]; e.err = bad;
        sb.push_back(e);
        lat = (op == 2'b11 && !bad) ? 3 : 2;
        exp_em = bad ? 8'h00 : (op == 2'b11 ? 8'b0000_0110 : 8'b0000_0010);
        exp_wm = bad ? 8'h00 : (op == 2'b11 ? 8'b0000_0100 : (op == 2'b10 ? 8'b0000_0010 : 8'h00));
        gm = '0; ogm = '0; dm = '0; em = '0; wm = '0;
        set_port(port, 1'b1, op, addr, wdata);
        for (int n = 1; n < 8; n++) begin
            @(negedge clk);
            gm[n]  = port ? p1_gnt  : p0_gnt;
            ogm[n] = port ? (p0_gnt | p0_done) : (p1_gnt | p1_done);
            dm[n]  = port ? p1_done : p0_done;
            em[n]  = mem_en;
            wm[n]  = mem_we;
            if (n == 1) set_port(port, 1'b0, 2'($urandom), 16'($urandom), 16'($urandom));
            if (dm[n]) break;
        end
        chk("gnt_timing", 32'(gm), 32'b10);
        chk("other_port_quiet", 32'(ogm), 32'h0);
        chk("done_latency", 32'(dm), 32'(1) << lat);
        chk("mem_en_cycles", 32'(em), 32'(exp_em));
        chk("mem_we_cycles", 32'(wm), 32'(exp_wm));
        @(negedge clk);
    endtask

    initial begin
        int         k;
        logic [3:0] order;
        logic [7:0] we_seen;

        tbl[0]  = '{0, 2'b00, 16'd0,      16'h0000, 16'h3142};
        tbl[1]  = '{1, 2'b11, 16'd4,      16'h00AB, 16'h0000};
        tbl[2]  = '{1, 2'b00, 16'd4,      16'h0000, 16'h56AB};
        tbl[3]  = '{0, 2'b01, 16'd6,      16'h0000, 16'h00AD};
        tbl[4]  = '{0, 2'b00, 16'd16,     16'h0000, 16'h0000};
        tbl[5]  = '{1, 2'b10, 16'd7,      16'hBEEF, 16'h0000};
        tbl[6]  = '{0, 2'b00, 16'd7,      16'h0000, 16'hBEEF};
        tbl[7]  = '{1, 2'b01, 16'd15,     16'h0000, 16'h000F};
        tbl[8]  = '{1, 2'b00, 16'hFFFF,   16'h0000, 16'h0000};
        tbl[9]  = '{0, 2'b11, 16'd15,     16'h1234, 16'h0000};
        tbl[10] = '{0, 2'b00, 16'd15,     16'h0000, 16'h1034};
        tbl[11] = '{1, 2'b01, 16'd6,      16'h0000, 16'h00AD};

        @(negedge clk);
        chk("rst_p0_rdata", p0_rdata, 16'h0);
        chk("rst_p1_rdata", p1_rdata, 16'h0);
        chk("rst_gnt_done_err", {p0_gnt, p1_gnt, p0_done, p1_done, p0_err, p1_err}, 6'b0);
        chk("rst_mem_strobes", {mem_en, mem_we}, 2'b0);
        chk("rst_mem_addr_wdata", {mem_addr, mem_wdata}, 32'h0);
        do_reset();

        for (int i = 0; i < 12; i++)
            do_access(tbl[i].port, tbl[i].op, tbl[i].addr, tbl[i].wdata, tbl[i].rexp);

        // Simultaneous requests held high: grants must alternate starting with p0.
        do_reset();
        for (int i = 0; i < 2; i++) begin
            sb.push_back('{0, 16'h1001, 1'b0});
            sb.push_back('{1, 16'h1002, 1'b0});
        end
        set_port(0, 1'b1, 2'b00, 16'd1, 16'h0);
        set_port(1, 1'b1, 2'b00, 16'd2, 16'h0);
        k = 0;
        order = '0;
        for (int n = 0; n < 30 && k < 4; n++) begin
            @(negedge clk);
            if (p0_gnt && p1_gnt) begin
                ntotal++;
                $display("FAIL tie_double_gnt: got both gnt expected one");
            end
            if (p0_gnt || p1_gnt) begin
                order[k] = p1_gnt;
                k++;
            end
        end
        p0_req = 1'b0;
        p1_req = 1'b0;
        chk("tie_grant_count", 32'(k), 32'd4);
        chk("tie_order", 32'(order), 32'b1010);
        for (int n = 0; n < 10 && sb.size() != 0; n++) @(negedge clk);
        chk("tie_sb_drained", 32'(sb.size()), 32'd0);
        @(negedge clk);

        // Reset in the MERGE cycle of a byte write abandons it.
        set_port(1, 1'b1, 2'b11, 16'd5, 16'h00CC);
        @(negedge clk);
        chk("merge_rst_gnt", p1_gnt, 1'b1);
        set_port(1, 1'b0, 2'b00, 16'd0, 16'h0);
        @(negedge clk);
        chk("merge_rst_we_in_merge", mem_we, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_last[0] = '0;
        exp_last[1] = '0;
        we_seen = '0;
        for (int n = 0; n < 4; n++) begin
            we_seen[n] = mem_we | p1_done | p0_done;
            @(negedge clk);
        end
        chk("merge_rst_quiet", 32'(we_seen), 32'h0);
        chk("merge_rst_p1_rdata", p1_rdata, 16'h0);
        do_access(0, 2'b00, 16'd3, 16'h0, 16'h1003);

        repeat (3) @(negedge clk);
        chk("sb_empty_at_end", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
